// File: rtl/cordic_vectoring.sv
// cordic_vectoring -- pipelined vectoring-mode CORDIC.
// Turns a Cartesian sample (xin, yin) into a gain-scaled magnitude and a
// binary-angle phase (2^Z_W = one full turn). One sample per clock, no
// backpressure. A sample presented with in_valid emerges STAGES+2 registers
// later: pre-rotation, STAGES micro-rotations, output register.
//
// Ports
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   xin/yin valid this cycle
//   xin, yin   in   signed XY_W-bit Cartesian components
//   out_valid  out  mag/zout updated this cycle
//   mag        out  unsigned XY_W+1 magnitude, K*sqrt(x^2+y^2), K ~= 1.6468
//   zout       out  atan2(yin, xin) in binary angle units (held while idle)
module cordic_vectoring #(
  parameter int XY_W   = 16,
  parameter int Z_W    = 32,
  parameter int STAGES = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic signed [XY_W-1:0] xin,
  input  logic signed [XY_W-1:0] yin,
  output logic                   out_valid,
  output logic        [XY_W:0]   mag,
  output logic        [Z_W-1:0]  zout
);

  // Two guard bits: one for -(-2^(XY_W-1)) in pre-rotation, one for CORDIC gain.
  localparam int XW = XY_W + 2;

  localparam logic [31:0] ATAN [0:15] = '{
    32'h20000000, 32'h12E4051D, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D
  };

  localparam logic [Z_W-1:0] Z_P90 = {2'b01, {(Z_W-2){1'b0}}};
  localparam logic [Z_W-1:0] Z_M90 = {2'b11, {(Z_W-2){1'b0}}};

  // Table is in 32-bit turns; narrower angle words keep the top bits.
  function automatic logic [Z_W-1:0] atan_z(input int i);
    return Z_W'(ATAN[i] >> (32 - Z_W));
  endfunction

  // Index 0 holds the pre-rotated sample; index i+1 holds the output of stage i.
  logic signed [XW-1:0]  x_q   [0:STAGES];
  logic signed [XW-1:0]  x_d   [0:STAGES];
  logic signed [XW-1:0]  y_q   [0:STAGES];
  logic signed [XW-1:0]  y_d   [0:STAGES];
  logic        [Z_W-1:0] z_q   [0:STAGES];
  logic        [Z_W-1:0] z_d   [0:STAGES];
  logic                  vld_q [0:STAGES];
  logic                  vld_d [0:STAGES];
  logic                  zf_q  [0:STAGES];
  logic                  zf_d  [0:STAGES];

  logic                  out_valid_q, out_valid_d;
  logic        [XY_W:0]  mag_q, mag_d;
  logic        [Z_W-1:0] zout_q, zout_d;

  logic signed [XW-1:0]  xs, ys;

  always_comb begin
    xs = {{2{xin[XY_W-1]}}, xin};
    ys = {{2{yin[XY_W-1]}}, yin};

    // Pre-rotation folds the left half-plane into x >= 0 so the
    // micro-rotations only need to cover +/-99.9 degrees.
    x_d[0]   = xs;
    y_d[0]   = ys;
    z_d[0]   = '0;
    vld_d[0] = in_valid;
    zf_d[0]  = (xin == '0) && (yin == '0);
    if (xin[XY_W-1]) begin
      if (!yin[XY_W-1]) begin
        x_d[0] = ys;
        y_d[0] = -xs;
        z_d[0] = Z_P90;
      end else begin
        x_d[0] = -ys;
        y_d[0] = xs;
        z_d[0] = Z_M90;
      end
    end

    // Drive y toward zero; z accumulates the rotation applied.
    for (int i = 0; i < STAGES; i++) begin
      vld_d[i+1] = vld_q[i];
      zf_d[i+1]  = zf_q[i];
      if (!y_q[i][XW-1]) begin
        x_d[i+1] = x_q[i] + (y_q[i] >>> i);
        y_d[i+1] = y_q[i] - (x_q[i] >>> i);
        z_d[i+1] = z_q[i] + atan_z(i);
      end else begin
        x_d[i+1] = x_q[i] - (y_q[i] >>> i);
        y_d[i+1] = y_q[i] + (x_q[i] >>> i);
        z_d[i+1] = z_q[i] - atan_z(i);
      end
    end

    out_valid_d = vld_q[STAGES];
    mag_d       = mag_q;
    zout_d      = zout_q;
    if (vld_q[STAGES]) begin
      if (zf_q[STAGES]) begin
        mag_d  = '0;
        zout_d = '0;
      end else begin
        // Final x is never negative, so dropping the sign bit is lossless.
        mag_d  = x_q[STAGES][XY_W:0];
        zout_d = z_q[STAGES];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= STAGES; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        z_q[i]   <= '0;
        vld_q[i] <= 1'b0;
        zf_q[i]  <= 1'b0;
      end
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      zout_q      <= '0;
    end else begin
      for (int i = 0; i <= STAGES; i++) begin
        x_q[i]   <= x_d[i];
        y_q[i]   <= y_d[i];
        z_q[i]   <= z_d[i];
        vld_q[i] <= vld_d[i];
        zf_q[i]  <= zf_d[i];
      end
      out_valid_q <= out_valid_d;
      mag_q       <= mag_d;
      zout_q      <= zout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign mag       = mag_q;
  assign zout      = zout_q;

endmodule
